reg_bank_writer: RTL and testbench
==================================

Name: reg_bank_writer

Overview:
- Write-side counterpart to the 32-to-1 read multiplexer used in the register file datapath.
- Accepts write requests (5-bit address, WIDTH-bit data) over a valid/ready handshake and decodes the address into one-hot load enables. It holds 32 registers whose outputs Q0..Q31 drive the read mux inputs I0..I31 directly.
- Adds a pipelined commit stage, a sequential clear-all sweep FSM, and a saturating commit counter.

Parameters:
- WIDTH, 32, data width of each register.
- ZERO_R0, 1, when 1 writes to address 0 are discarded and Q0 stays 0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- wr_valid  input  1  write request valid.
- wr_ready  output  1  write request accepted this cycle when wr_valid and wr_ready are both 1.
- wr_addr  input  5  target register index.
- wr_data  input  WIDTH  write data.
- clr_req  input  1  request to clear all 32 registers.
- clr_done  output  1  one-cycle pulse when the sweep completes.
- busy  output  1  high while a commit is pending or a sweep is active.
- wr_count  output  16  number of committed writes, saturating.
- Q0..Q31  output  WIDTH each  register contents, feeding mux inputs I0..I31.

Behaviour:
- Reset (asynchronous, immediate):
  - Q0..Q31 = 0, stage_v = 0, state = IDLE, cnt = 0.
  - clr_done = 0, wr_count = 0, wr_ready = 0 while rst is high.
  - Reset asserted mid-sweep or with a commit pending aborts the operation; the pending write is lost.
- FSM states: IDLE, SWEEP.
- wr_ready = (state == IDLE) && !clr_req && !rst, combinational.
- Accept at edge E (wr_valid && wr_ready):
  - stage_v <= 1; stage_addr and stage_data capture wr_addr and wr_data.
- Commit at edge E+1 if stage_v:
  - Q[stage_addr] <= stage_data, unless ZERO_R0 == 1 and stage_addr == 0, in which case the write is discarded.
  - stage_v <= 1 only if a new request is accepted at that edge, otherwise 0.
  - Back-to-back accepts sustain 1 write per cycle.
- Latency: data presented at edge E is visible on Q after edge E+1. There is no bypass.
- Only the addressed register changes; all others hold their value.
- wr_count increments by 1 per non-discarded commit and saturates at 16'hFFFF.
- Clear sweep:
  - In IDLE, clr_req = 1 at edge E: state <= SWEEP, cnt <= 0. Any pending stage write still commits at E.
  - clr_req has priority over wr_valid in the same cycle: the write is not accepted and must be held by the source.
  - Edges E+1..E+32: Q[cnt] <= 0, cnt increments, and cnt wraps 31 -> 0.
  - At edge E+32 (clearing Q31): state <= IDLE, clr_done <= 1 for exactly one cycle.
  - clr_req is ignored while in SWEEP.
  - wr_count is not altered by the sweep.
- busy = stage_v || (state == SWEEP).
- Address 31 is a valid address; there is no address wrap on the write side.

Test Plan:
- Reset then single write addr=5, data=32'hDEADBEEF:
  - wr_ready = 1; Q5 = DEADBEEF after the second edge, all other Q = 0, wr_count = 1.
- Back-to-back writes addr 1..31 with data = addr, wr_valid held for 31 cycles:
  - One accept per cycle; Qn = n for every n; wr_count = 31.
- Write addr=0, data=32'hFFFFFFFF, ZERO_R0 = 1:
  - Q0 stays 0 and wr_count is unchanged.
  - Repeat with ZERO_R0 = 0: Q0 = FFFFFFFF.
- Load all registers with nonzero values, then assert clr_req together with wr_valid (addr=3):
  - wr_ready = 0 and the write is not taken.
  - Q0..Q31 clear in index order over 32 cycles, clr_done pulses once on the 33rd cycle, busy is high throughout, then wr_ready = 1.
- Accept a write to addr=7 in the same cycle that clr_req is raised on the next cycle:
  - Q7 is written at the transition edge, then cleared during the sweep.
- Assert rst mid-sweep at cnt = 10 with nonzero Q20:
  - All Q = 0 immediately, state = IDLE, no clr_done pulse; normal writes work after rst is released.

Source files
------------

// File: rtl/reg_bank_writer.sv
// reg_bank_writer: write side of a 32-entry register file. It accepts writes over
// valid/ready, stages them, commits them one edge later, and offers a clear-all sweep.
// Latency: data accepted at edge E appears on Q after edge E+1. There is no bypass path.
// Backpressure: wr_ready is low while a sweep runs or clr_req is high, and the source holds the request.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   wr_valid/wr_ready    write request handshake, with wr_addr (5b) and wr_data (WIDTH)
//   clr_req, clr_done    start a clear-all sweep; one-cycle pulse when the sweep ends
//   busy                 a commit is pending or a sweep is running
//   wr_count             saturating count of committed (non-discarded) writes
//   Q0..Q31              register contents, wired directly to read mux inputs I0..I31
module reg_bank_writer #(
  parameter int WIDTH   = 32,
  parameter int ZERO_R0 = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [4:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_req,
  output logic             clr_done,
  output logic             busy,
  output logic [15:0]      wr_count,
  output logic [WIDTH-1:0] Q0,  Q1,  Q2,  Q3,  Q4,  Q5,  Q6,  Q7,
  output logic [WIDTH-1:0] Q8,  Q9,  Q10, Q11, Q12, Q13, Q14, Q15,
  output logic [WIDTH-1:0] Q16, Q17, Q18, Q19, Q20, Q21, Q22, Q23,
  output logic [WIDTH-1:0] Q24, Q25, Q26, Q27, Q28, Q29, Q30, Q31
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state, state_nxt;
  logic [4:0]       cnt, cnt_nxt;
  logic             clr_done_nxt;
  logic             sweep_clr;
  logic             accept;
  logic             commit;
  logic             stage_v;
  logic [4:0]       stage_addr;
  logic [WIDTH-1:0] stage_data;
  logic [WIDTH-1:0] q [32];

  // clr_req takes priority over a write offered in the same cycle.
  assign wr_ready = (state == IDLE) && !clr_req && !rst;
  assign accept   = wr_valid && wr_ready;
  // A write to register 0 is dropped when R0 is hardwired to zero. It is not counted either.
  assign commit   = stage_v && !((ZERO_R0 != 0) && (stage_addr == 5'd0));
  assign busy     = stage_v || (state == SWEEP);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    clr_done_nxt = 1'b0;
    sweep_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = SWEEP;
          cnt_nxt   = 5'd0;
        end
      end
      SWEEP: begin
        sweep_clr = 1'b1;
        cnt_nxt   = cnt + 5'd1;   // wraps 31 -> 0 naturally
        if (cnt == 5'd31) begin
          state_nxt    = IDLE;
          clr_done_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      clr_done <= clr_done_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_v    <= 1'b0;
      stage_addr <= 5'd0;
      stage_data <= '0;
    end else begin
      stage_v <= accept;
      if (accept) begin
        stage_addr <= wr_addr;
        stage_data <= wr_data;
      end
    end
  end

  // A commit and a sweep clear never coincide. Nothing is accepted once the sweep
  // starts, and any pending stage commits on the IDLE->SWEEP edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) q[i] <= '0;
    end else begin
      if (commit)    q[stage_addr] <= stage_data;
      if (sweep_clr) q[cnt]        <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wr_count <= 16'd0;
    else if (commit && (wr_count != 16'hFFFF))
      wr_count <= wr_count + 16'd1;
  end

  assign Q0  = q[0];  assign Q1  = q[1];  assign Q2  = q[2];  assign Q3  = q[3];
  assign Q4  = q[4];  assign Q5  = q[5];  assign Q6  = q[6];  assign Q7  = q[7];
  assign Q8  = q[8];  assign Q9  = q[9];  assign Q10 = q[10]; assign Q11 = q[11];
  assign Q12 = q[12]; assign Q13 = q[13]; assign Q14 = q[14]; assign Q15 = q[15];
  assign Q16 = q[16]; assign Q17 = q[17]; assign Q18 = q[18]; assign Q19 = q[19];
  assign Q20 = q[20]; assign Q21 = q[21]; assign Q22 = q[22]; assign Q23 = q[23];
  assign Q24 = q[24]; assign Q25 = q[25]; assign Q26 = q[26]; assign Q27 = q[27];
  assign Q28 = q[28]; assign Q29 = q[29]; assign Q30 = q[30]; assign Q31 = q[31];

endmodule

// File: tb/tb_reg_bank_writer.sv
// tb_reg_bank_writer: directed bench for reg_bank_writer.
// Two instances share the same stimulus: dut hardwires R0 to zero and dut0 has a writable R0.
// Expected values are constants derived by hand from the stimulus below.
module tb_reg_bank_writer;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clr_req;
  logic        wr_ready, clr_done, busy;
  logic        wr_ready0, clr_done0, busy0;
  logic [15:0] wr_count, wr_count0;
  logic [31:0] q1 [32];
  logic [31:0] q0d [32];
  int          tests;
  int          fails;
  logic        seen;

  reg_bank_writer #(.WIDTH(32), .ZERO_R0(1)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .clr_req(clr_req), .clr_done(clr_done), .busy(busy), .wr_count(wr_count),
    .Q0(q1[0]),   .Q1(q1[1]),   .Q2(q1[2]),   .Q3(q1[3]),   .Q4(q1[4]),   .Q5(q1[5]),   .Q6(q1[6]),   .Q7(q1[7]),
    .Q8(q1[8]),   .Q9(q1[9]),   .Q10(q1[10]), .Q11(q1[11]), .Q12(q1[12]), .Q13(q1[13]), .Q14(q1[14]), .Q15(q1[15]),
    .Q16(q1[16]), .Q17(q1[17]), .Q18(q1[18]), .Q19(q1[19]), .Q20(q1[20]), .Q21(q1[21]), .Q22(q1[22]), .Q23(q1[23]),
    .Q24(q1[24]), .Q25(q1[25]), .Q26(q1[26]), .Q27(q1[27]), .Q28(q1[28]), .Q29(q1[29]), .Q30(q1[30]), .Q31(q1[31])
  );

  reg_bank_writer #(.WIDTH(32), .ZERO_R0(0)) dut0 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready0), .wr_addr(wr_addr),
    .wr_data(wr_data), .clr_req(clr_req), .clr_done(clr_done0), .busy(busy0), .wr_count(wr_count0),
    .Q0(q0d[0]),   .Q1(q0d[1]),   .Q2(q0d[2]),   .Q3(q0d[3]),   .Q4(q0d[4]),   .Q5(q0d[5]),   .Q6(q0d[6]),   .Q7(q0d[7]),
    .Q8(q0d[8]),   .Q9(q0d[9]),   .Q10(q0d[10]), .Q11(q0d[11]), .Q12(q0d[12]), .Q13(q0d[13]), .Q14(q0d[14]), .Q15(q0d[15]),
    .Q16(q0d[16]), .Q17(q0d[17]), .Q18(q0d[18]), .Q19(q0d[19]), .Q20(q0d[20]), .Q21(q0d[21]), .Q22(q0d[22]), .Q23(q0d[23]),
    .Q24(q0d[24]), .Q25(q0d[25]), .Q26(q0d[26]), .Q27(q0d[27]), .Q28(q0d[28]), .Q29(q0d[29]), .Q30(q0d[30]), .Q31(q0d[31])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_valid = 1'b0; clr_req = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    tests = 0; fails = 0; seen = 1'b0;
    rst = 1'b1; wr_valid = 1'b0; wr_addr = 5'd0; wr_data = 32'd0; clr_req = 1'b0;
    #1;
    // Reset state
    for (int i = 0; i < 32; i++) chk($sformatf("rst_q%0d", i), q1[i], 32'd0);
    chk("rst_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_count", {16'd0, wr_count}, 32'd0);
    chk("rst_done",  {31'd0, clr_done}, 32'd0);
    chk("rst_busy",  {31'd0, busy},     32'd0);
    tick();
    rst = 1'b0;
    #1;

    // Single write addr 5: visible after the second edge, not after the first.
    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    #1;
    chk("w5_ready", {31'd0, wr_ready}, 32'd1);
    tick();
    wr_valid = 1'b0;
    chk("w5_busy_pending", {31'd0, busy}, 32'd1);
    chk("w5_no_bypass", q1[5], 32'd0);
    tick();
    chk("w5_q5", q1[5], 32'hDEADBEEF);
    for (int i = 0; i < 32; i++) if (i != 5) chk($sformatf("w5_q%0d", i), q1[i], 32'd0);
    chk("w5_count", {16'd0, wr_count}, 32'd1);
    chk("w5_busy_idle", {31'd0, busy}, 32'd0);

    // Back-to-back writes to addr 1..31 with data = addr, from a fresh reset.
    do_reset();
    for (int n = 1; n < 32; n++) begin
      wr_valid = 1'b1; wr_addr = 5'(n); wr_data = 32'(n);
      #1;
      chk($sformatf("b2b_ready%0d", n), {31'd0, wr_ready}, 32'd1);
      tick();
    end
    wr_valid = 1'b0;
    tick();
    for (int n = 1; n < 32; n++) chk($sformatf("b2b_q%0d", n), q1[n], 32'(n));
    chk("b2b_count", {16'd0, wr_count}, 32'd31);

    // Write to addr 0: discarded with ZERO_R0=1, stored with ZERO_R0=0.
    wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    tick();
    wr_valid = 1'b0;
    tick();
    chk("r0_q0_zero",   q1[0], 32'd0);
    chk("r0_count",     {16'd0, wr_count}, 32'd31);
    chk("r0_q0_write",  q0d[0], 32'hFFFFFFFF);
    chk("r0_count_nz",  {16'd0, wr_count0}, 32'd32);

    // clr_req together with a write to addr 3. The write waits; the source holds it.
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000AAAA; clr_req = 1'b1;
    #1;
    chk("clr_ready_blocked", {31'd0, wr_ready}, 32'd0);
    tick();
    clr_req = 1'b0;
    chk("clr_busy_start", {31'd0, busy}, 32'd1);
    chk("clr_ready_sweep", {31'd0, wr_ready}, 32'd0);
    for (int k = 0; k < 32; k++) begin
      tick();
      chk($sformatf("clr_q%0d", k), q1[k], 32'd0);
      if (k == 0) chk("clr_q0_nz", q0d[0], 32'd0);
      if (k < 31) begin
        chk($sformatf("clr_hold_q%0d", k + 1), q1[k + 1], 32'(k + 1));
        chk($sformatf("clr_busy%0d", k), {31'd0, busy}, 32'd1);
        chk($sformatf("clr_nodone%0d", k), {31'd0, clr_done}, 32'd0);
      end else begin
        chk("clr_done_pulse", {31'd0, clr_done}, 32'd1);
        chk("clr_busy_end", {31'd0, busy}, 32'd0);
        chk("clr_ready_after", {31'd0, wr_ready}, 32'd1);
      end
    end
    chk("clr_count_kept", {16'd0, wr_count}, 32'd31);
    tick();
    wr_valid = 1'b0;
    chk("clr_done_once", {31'd0, clr_done}, 32'd0);
    chk("held_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("held_q3", q1[3], 32'h0000AAAA);
    chk("held_count", {16'd0, wr_count}, 32'd32);

    // Write addr 7, then clr_req on the next cycle: commits at the transition edge, then clears.
    wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'h00000077;
    tick();
    wr_valid = 1'b0; clr_req = 1'b1;
    #1;
    chk("a7_ready_blocked", {31'd0, wr_ready}, 32'd0);
    tick();
    clr_req = 1'b0;
    chk("a7_committed", q1[7], 32'h00000077);
    chk("a7_count", {16'd0, wr_count}, 32'd33);
    for (int k = 0; k < 32; k++) begin
      tick();
      if (k == 6)  chk("a7_before_clear", q1[7], 32'h00000077);
      if (k == 7)  chk("a7_cleared", q1[7], 32'd0);
      if (k == 31) chk("a7_done", {31'd0, clr_done}, 32'd1);
    end
    tick();

    // Reset asserted mid-sweep while cnt = 10, with Q20 nonzero.
    wr_valid = 1'b1; wr_addr = 5'd20; wr_data = 32'h00002020;
    tick();
    wr_valid = 1'b0;
    tick();
    chk("mr_q20", q1[20], 32'h00002020);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    chk("mr_q20_pre", q1[20], 32'h00002020);
    chk("mr_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) chk($sformatf("mr_q%0d", i), q1[i], 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_ready", {31'd0, wr_ready}, 32'd0);
    chk("mr_count", {16'd0, wr_count}, 32'd0);
    chk("mr_done", {31'd0, clr_done}, 32'd0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (clr_done) seen = 1'b1;
    end
    chk("mr_no_done", {31'd0, seen}, 32'd0);
    chk("mr_idle_busy", {31'd0, busy}, 32'd0);
    wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000099;
    #1;
    chk("mr_ready_after", {31'd0, wr_ready}, 32'd1);
    tick();
    wr_valid = 1'b0;
    tick();
    chk("mr_q9", q1[9], 32'h00000099);
    chk("mr_count_after", {16'd0, wr_count}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
